rle_acq_seq: RTL and testbench

Acquisition sequencer placed in front of the RLE compressor. It frames a free-running sample stream into one acquisition: start, pre-trigger samples, trigger wait, post-trigger samples, and a TLAST on the final sample. It drives the compressor's ctl_rst and cfg_ena, and watches the compressor's output stream so it knows when the compressed frame has fully drained. It also counts compressed words for status readout.

---
 rtl/rle_acq_seq.sv | 186 ++++++++++++++++++
 tb/tb_rle_acq_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_acq_seq.sv
// rtl/rle_acq_seq.sv - acquisition framing sequencer in front of the RLE compressor
module rle_acq_seq #(
  parameter int DW  = 8,
  parameter int CNW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctl_start,
  input  logic           ctl_stop,
  input  logic           trg,
  input  logic           cfg_ena,
  input  logic [CNW-1:0] cfg_pre,
  input  logic [CNW-1:0] cfg_pst,
  input  logic [DW-1:0]  sti_tdata,
  input  logic           sti_tvalid,
  output logic           sti_tready,
  output logic [DW-1:0]  sto_tdata,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  input  logic           sto_tready,
  output logic           rle_rst,
  output logic           rle_ena,
  input  logic           mon_tvalid,
  input  logic           mon_tready,
  input  logic           mon_tlast,
  output logic [2:0]     sts_state,
  output logic           sts_busy,
  output logic [CNW-1:0] sts_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_PRE   = 3'd2,
    S_WTRG  = 3'd3,
    S_POST  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  localparam logic [CNW-1:0] CNT_ONE  = {{(CNW-1){1'b0}}, 1'b1};
  localparam logic [CNW-1:0] CNT_ZERO = '0;
  localparam logic [CNW-1:0] CNT_MAX  = '1;

  state_t         state;
  state_t         state_nxt;
  logic [CNW-1:0] pre_cnt;
  logic [CNW-1:0] pst_cnt;
  logic [CNW-1:0] pre_inc;
  logic [CNW-1:0] pst_inc;
  logic [CNW-1:0] pst_tgt;
  logic [CNW-1:0] cnt_q;
  logic           stop_pend;
  logic           abort_q;
  logic           ena_q;
  logic           pass;
  logic           xfer;
  logic           stop_eff;
  logic           pst_last;
  logic           mon_hs;
  logic           start_go;
  logic           abort_go;

  // A zero post count still emits one sample so every frame has a tlast.
  assign pst_tgt  = (cfg_pst == CNT_ZERO) ? CNT_ONE : cfg_pst;
  assign pre_inc  = pre_cnt + CNT_ONE;
  assign pst_inc  = pst_cnt + CNT_ONE;

  assign pass     = (state == S_PRE) || (state == S_WTRG) || (state == S_POST);
  assign xfer     = pass && sti_tvalid && sto_tready;
  // A stop pulse takes effect in its own cycle and stays pending until a transfer closes the frame.
  assign stop_eff = ctl_stop || stop_pend;
  assign pst_last = (state == S_POST) && (pst_inc == pst_tgt);
  assign mon_hs   = mon_tvalid && mon_tready;

  assign sto_tdata = sti_tdata;
  assign rle_ena   = ena_q;
  assign sts_state = state;
  assign sts_busy  = (state != S_IDLE);
  assign sts_cnt   = cnt_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and stream/compressor control outputs.
  always_comb begin
    state_nxt  = state;
    start_go   = 1'b0;
    abort_go   = 1'b0;
    sto_tvalid = 1'b0;
    sto_tlast  = 1'b0;
    sti_tready = 1'b1;
    rle_rst    = abort_q;

    if (pass) begin
      sto_tvalid = sti_tvalid;
      sti_tready = sto_tready;
      sto_tlast  = sti_tvalid && (stop_eff || pst_last);
    end

    case (state)
      S_IDLE: begin
        if (ctl_start && !ctl_stop) begin
          state_nxt = S_RST;
          start_go  = 1'b1;
        end
      end
      S_RST: begin
        rle_rst   = 1'b1;
        state_nxt = (cfg_pre == CNT_ZERO) ? S_WTRG : S_PRE;
      end
      S_PRE: begin
        if (xfer) begin
          if (stop_eff) begin
            state_nxt = S_FLUSH;
          end else if (pre_inc == cfg_pre) begin
            state_nxt = S_WTRG;
          end
        end
      end
      S_WTRG: begin
        if (xfer && stop_eff) begin
          state_nxt = S_FLUSH;
        end else if (trg && !stop_eff) begin
          state_nxt = S_POST;
        end
      end
      S_POST: begin
        if (xfer && (stop_eff || pst_last)) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (ctl_stop) begin
          abort_go  = 1'b1;
          state_nxt = S_IDLE;
        end else if (mon_hs && mon_tlast) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame counters, pending stop, abort pulse, enable latch and compressed-word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= CNT_ZERO;
      pst_cnt   <= CNT_ZERO;
      cnt_q     <= CNT_ZERO;
      stop_pend <= 1'b0;
      abort_q   <= 1'b0;
      ena_q     <= 1'b0;
    end else begin
      abort_q <= abort_go;
      if (start_go) begin
        ena_q     <= cfg_ena;
        pre_cnt   <= CNT_ZERO;
        pst_cnt   <= CNT_ZERO;
        cnt_q     <= CNT_ZERO;
        stop_pend <= 1'b0;
      end else begin
        if ((state == S_PRE) && xfer) begin
          pre_cnt <= pre_inc;
        end
        if ((state == S_POST) && xfer) begin
          pst_cnt <= pst_inc;
        end
        if (pass && ctl_stop) begin
          stop_pend <= 1'b1;
        end
        if ((state != S_IDLE) && mon_hs && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_acq_seq.sv
// tb/tb_rle_acq_seq.sv - directed self-checking bench for rle_acq_seq
module tb_rle_acq_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctl_start, ctl_stop, trg, cfg_ena;
  logic [3:0] cfg_pre, cfg_pst;
  logic [7:0] sti_tdata;
  logic       sti_tvalid, sti_tready;
  logic [7:0] sto_tdata;
  logic       sto_tvalid, sto_tlast, sto_tready;
  logic       rle_rst, rle_ena;
  logic       mon_tvalid, mon_tready, mon_tlast;
  logic [2:0] sts_state;
  logic       sts_busy;
  logic [3:0] sts_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int xfers;

  always #5 clk = ~clk;

  rle_acq_seq #(.DW(8), .CNW(4)) dut (
    .clk(clk), .rst(rst),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .trg(trg), .cfg_ena(cfg_ena),
    .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
    .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast), .sto_tready(sto_tready),
    .rle_rst(rle_rst), .rle_ena(rle_ena),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .sts_state(sts_state), .sts_busy(sts_busy), .sts_cnt(sts_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_last();
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    tick();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic start_frame(input logic [3:0] pre, input logic [3:0] pst, input logic ena);
    cfg_pre   = pre;
    cfg_pst   = pst;
    cfg_ena   = ena;
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctl_start = 0; ctl_stop = 0; trg = 0; cfg_ena = 0;
    cfg_pre = 0; cfg_pst = 0;
    sti_tdata = 8'h00; sti_tvalid = 0; sto_tready = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    #2;
    chk("rst_state", sts_state, 0);
    chk("rst_tvalid", sto_tvalid, 0);
    chk("rst_tready", sti_tready, 1);
    chk("rst_rle_rst", rle_rst, 0);
    chk("rst_rle_ena", rle_ena, 0);
    chk("rst_cnt", sts_cnt, 0);
    chk("rst_busy", sts_busy, 0);
    tick(); tick();
    rst = 1'b0;

    // Normal frame: pre=3, pst=2, trigger five cycles into WTRG.
    sti_tvalid = 1; sto_tready = 1; sti_tdata = 8'h10;
    #1;
    chk("idle_no_valid", sto_tvalid, 0);
    start_frame(4'd3, 4'd2, 1'b1);
    #1;
    chk("n_rst_state", sts_state, 1);
    chk("n_rst_pulse", rle_rst, 1);
    chk("n_ena", rle_ena, 1);
    chk("n_rst_novalid", sto_tvalid, 0);
    tick();
    chk("n_rst_one_cycle", rle_rst, 0);
    for (int i = 0; i < 3; i++) begin
      sti_tdata = 8'h10 + 8'(i);
      #1;
      chk("n_pre_state", sts_state, 2);
      chk("n_pre_valid", sto_tvalid, 1);
      chk("n_pre_data", sto_tdata, 8'h10 + 8'(i));
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      sti_tdata = 8'h30 + 8'(j);
      #1;
      chk("n_wtrg_state", sts_state, 3);
      chk("n_wtrg_data", sto_tdata, 8'h30 + 8'(j));
      chk("n_wtrg_nolast", sto_tlast, 0);
      tick();
    end
    trg = 1;
    #1;
    chk("n_trg_cycle", sts_state, 3);
    tick();
    trg = 0;
    sti_tdata = 8'h40;
    #1;
    chk("n_post_state", sts_state, 4);
    chk("n_post1_last", sto_tlast, 0);
    tick();
    sti_tdata = 8'h41;
    #1;
    chk("n_post2_last", sto_tlast, 1);
    chk("n_post2_data", sto_tdata, 8'h41);
    tick();
    sto_tready = 0;
    #1;
    chk("n_flush_state", sts_state, 5);
    chk("n_flush_novalid", sto_tvalid, 0);
    chk("n_flush_tready", sti_tready, 1);
    tick();
    chk("n_flush_wait", sts_state, 5);
    mon_last();
    #1;
    chk("n_idle", sts_state, 0);
    chk("n_cnt", sts_cnt, 1);
    chk("n_ena_held", rle_ena, 1);
    chk("n_busy", sts_busy, 0);

    // Backpressure: sto_tready toggles 0/1, PRE must count exactly three transfers.
    sto_tready = 1;
    start_frame(4'd3, 4'd2, 1'b0);
    tick();
    xfers = 0;
    for (int k = 0; k < 6; k++) begin
      sto_tready = k[0];
      sti_tdata  = 8'h20 + 8'(xfers);
      #1;
      chk("b_pre_state", sts_state, 2);
      chk("b_ready_mirror", sti_tready, k[0]);
      chk("b_pre_data", sto_tdata, 8'h20 + 8'(xfers));
      if (k[0]) xfers++;
      tick();
    end
    chk("b_wtrg", sts_state, 3);
    chk("b_ena0", rle_ena, 0);
    sto_tready = 0; trg = 1;
    tick();
    trg = 0;
    #1;
    chk("b_post_l0", sto_tlast, 0);
    sto_tready = 1;
    tick();
    sto_tready = 0;
    #1;
    chk("b_post_l1", sto_tlast, 1);
    chk("b_post_hold", sts_state, 4);
    sto_tready = 1;
    tick();
    chk("b_flush", sts_state, 5);
    mon_last();
    #1;
    chk("b_idle", sts_state, 0);

    // Stop together with trg in WTRG: no POST, next transfer closes the frame.
    start_frame(4'd0, 4'd2, 1'b1);
    tick();
    chk("s_wtrg_direct", sts_state, 3);
    sto_tready = 0; ctl_stop = 1; trg = 1;
    #1;
    chk("s_stop_cycle_last", sto_tlast, 1);
    tick();
    ctl_stop = 0; trg = 0;
    #1;
    chk("s_no_post", sts_state, 3);
    chk("s_pend_last", sto_tlast, 1);
    sto_tready = 1;
    tick();
    chk("s_flush", sts_state, 5);
    mon_last();
    #1;
    chk("s_idle", sts_state, 0);

    // cfg_pst=0: first POST transfer is the last one.
    start_frame(4'd0, 4'd0, 1'b1);
    tick();
    trg = 1;
    tick();
    trg = 0;
    #1;
    chk("z_post", sts_state, 4);
    chk("z_last", sto_tlast, 1);
    tick();
    chk("z_flush", sts_state, 5);

    // Abort in FLUSH.
    ctl_stop = 1;
    #1;
    chk("a_pre_rst", rle_rst, 0);
    tick();
    ctl_stop = 0;
    #1;
    chk("a_idle", sts_state, 0);
    chk("a_rst_pulse", rle_rst, 1);
    tick();
    chk("a_rst_end", rle_rst, 0);
    mon_last();
    #1;
    chk("a_late_tlast", sts_state, 0);
    chk("a_cnt_idle", sts_cnt, 0);

    // Async reset in the middle of POST.
    start_frame(4'd0, 4'd5, 1'b1);
    tick();
    trg = 1;
    tick();
    trg = 0;
    tick();
    sto_tready = 0;
    #1;
    chk("r_post", sts_state, 4);
    chk("r_tready0", sti_tready, 0);
    #2;
    rst = 1;
    #1;
    chk("r_state", sts_state, 0);
    chk("r_valid", sto_tvalid, 0);
    chk("r_tready", sti_tready, 1);
    chk("r_ena", rle_ena, 0);
    tick();
    rst = 0;

    // Compressed-word counter saturation, then start+stop together in IDLE.
    start_frame(4'd0, 4'd2, 1'b1);
    tick();
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) chk("c_cnt10", sts_cnt, 10);
      if (k == 15) chk("c_cnt15", sts_cnt, 15);
    end
    chk("c_sat", sts_cnt, 15);
    mon_tvalid = 0; mon_tready = 0;
    ctl_stop = 1; sto_tready = 1;
    #1;
    chk("c_stop_last", sto_tlast, 1);
    tick();
    ctl_stop = 0;
    #1;
    chk("c_flush", sts_state, 5);
    mon_last();
    #1;
    chk("c_idle", sts_state, 0);
    chk("c_held", sts_cnt, 15);
    ctl_start = 1; ctl_stop = 1;
    tick();
    ctl_start = 0; ctl_stop = 0;
    #1;
    chk("ss_idle", sts_state, 0);
    chk("ss_no_rst", rle_rst, 0);
    chk("ss_cnt", sts_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
